// File: rtl/regf_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters that stall
// issue on RAW hazards, counter saturation and (optionally) WAW hazards.
module regf_scoreboard #(
    parameter int AWIDTH    = 5,
    parameter int CWIDTH    = 2,
    parameter int NWB       = 2,
    parameter int WAW_STALL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  flush_pipeline,
    input  logic                  dest_en,
    input  logic [AWIDTH-1:0]     dest_addr,
    input  logic [NWB-1:0]        wec,
    input  logic [NWB*AWIDTH-1:0] addrc,
    input  logic                  a_en,
    input  logic [AWIDTH-1:0]     addra,
    input  logic                  b_en,
    input  logic [AWIDTH-1:0]     addrb,
    output logic                  stall_regf,
    output logic                  safe_switch,
    output logic                  sb_err
);

    localparam int NREG = 1 << AWIDTH;
    localparam int SW   = CWIDTH + 2;
    localparam logic [CWIDTH-1:0] CMAX = '1;

    logic [CWIDTH-1:0] cnt     [NREG];
    logic [CWIDTH-1:0] cnt_nxt [NREG];
    logic [SW-1:0]     dec     [NREG];
    logic [NREG-1:0]   uflow;
    logic              pend_a;
    logic              pend_b;
    logic              full;
    logic              waw;
    logic              issue;

    function automatic logic signed [SW-1:0] net_count(
        input logic [CWIDTH-1:0] c,
        input logic              i,
        input logic [SW-1:0]     d
    );
        return $signed({2'b00, c}) + $signed({{(SW-1){1'b0}}, i}) - $signed(d);
    endfunction

    // A negative net count means a write-back with nothing pending; pin it at zero.
    function automatic logic [CWIDTH-1:0] clamp_count(input logic signed [SW-1:0] s);
        return (s < 0) ? '0 : s[CWIDTH-1:0];
    endfunction

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int i = 0; i < NWB; i++) begin
                if (wec[i] && (addrc[i*AWIDTH +: AWIDTH] == AWIDTH'(r))) begin
                    dec[r] = dec[r] + SW'(1);
                end
            end
        end
    end

    // A same-cycle write-back only clears the hazard when it retires the last pending write.
    always_comb begin
        pend_a = a_en && ({2'b00, cnt[addra]} > dec[addra]);
        pend_b = b_en && ({2'b00, cnt[addrb]} > dec[addrb]);
        full   = dest_en && (cnt[dest_addr] == CMAX) && (dec[dest_addr] == '0);
        waw    = (WAW_STALL != 0) && dest_en && ({2'b00, cnt[dest_addr]} > dec[dest_addr]);
        stall_regf = (pend_a || pend_b || full || waw) && !flush_pipeline;
        issue  = dest_en && !stall && !halt && !stall_regf && !flush_pipeline;
    end

    always_comb begin
        safe_switch = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (cnt[r] != '0) begin
                safe_switch = 1'b0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic signed [SW-1:0] s;
            s          = net_count(cnt[r], issue && (dest_addr == AWIDTH'(r)), dec[r]);
            uflow[r]   = (s < 0);
            cnt_nxt[r] = clamp_count(s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else if (flush_pipeline) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (|uflow) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule
